// File: rtl/csidh_host_link.sv
// Host-side driver for the 64-bit CSIDH core port: streams coefficient and key words in, reassembles the result.
// Optional WAIT-state watchdog: define CSIDH_LINK_TIMEOUT_EN (otherwise timeout is tied 0).
module csidh_host_link #(
  parameter int unsigned N              = 512,
  parameter int unsigned KEY_BITS       = 296,
  parameter int unsigned WORD           = 64,
  parameter int unsigned KEY_CHUNKS     = 6,
  parameter int unsigned OUT_LAT        = 1,
  parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N-1:0]        a_in,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic [N-1:0]        result,
  output logic                result_valid,
  output logic                result_inv,
  output logic                timeout,
  output logic                core_rst,
  output logic [WORD-1:0]     core_in,
  input  logic [WORD-1:0]     core_out,
  input  logic                core_done,
  input  logic                core_invalid
);

  localparam int unsigned CHUNK     = N / WORD;
  localparam int unsigned KPAD      = KEY_CHUNKS * WORD;
  localparam logic [3:0]  A_LAST    = 4'(CHUNK - 1);
  localparam logic [3:0]  K_LAST    = 4'(KEY_CHUNKS - 1);
  localparam logic [3:0]  SKIP_LAST = (OUT_LAT > 1) ? 4'(OUT_LAT - 2) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_SEND_A,
    S_SEND_K,
    S_WAIT,
    S_SKIP,
    S_CAPT,
    S_FIN
  } state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic [3:0]      cnt_nx;
  int unsigned     nx_i;
  int unsigned     cur_i;
  logic [N-1:0]    a_q;
  logic [KPAD-1:0] key_q;
  logic [N-1:0]    result_q;
  logic            rv_q;
  logic            inv_q;
  logic            busy_q;
  logic            core_rst_q;
  logic [WORD-1:0] core_in_q;

`ifdef CSIDH_LINK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] wait_q;
  logic          timeout_q;
`endif

  assign cnt_nx = cnt_q + 4'd1;
  assign nx_i   = 32'(cnt_nx);
  assign cur_i  = 32'(cnt_q);

  // Outputs are registered: each state loads the word the core must see in the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      key_q      <= '0;
      result_q   <= '0;
      rv_q       <= 1'b0;
      inv_q      <= 1'b0;
      busy_q     <= 1'b0;
      core_rst_q <= 1'b1;
      core_in_q  <= '0;
`ifdef CSIDH_LINK_TIMEOUT_EN
      wait_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      rv_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a_in;
            key_q   <= KPAD'(key_in);
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_CRST;
`ifdef CSIDH_LINK_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end
        end
        S_CRST: begin
          core_rst_q <= 1'b0;
          core_in_q  <= a_q[WORD-1:0];
          cnt_q      <= '0;
          state_q    <= S_SEND_A;
        end
        S_SEND_A: begin
          if (cnt_q == A_LAST) begin
            core_in_q <= key_q[WORD-1:0];
            cnt_q     <= '0;
            state_q   <= S_SEND_K;
          end else begin
            core_in_q <= a_q[nx_i*WORD +: WORD];
            cnt_q     <= cnt_nx;
          end
        end
        S_SEND_K: begin
          if (cnt_q == K_LAST) begin
            core_in_q <= '0;
            cnt_q     <= '0;
            state_q   <= S_WAIT;
`ifdef CSIDH_LINK_TIMEOUT_EN
            wait_q    <= '0;
`endif
          end else begin
            core_in_q <= key_q[nx_i*WORD +: WORD];
            cnt_q     <= cnt_nx;
          end
        end
        S_WAIT: begin
          if (core_done) begin
            cnt_q <= '0;
            if (OUT_LAT > 1) state_q <= S_SKIP;
            else             state_q <= S_CAPT;
          end
`ifdef CSIDH_LINK_TIMEOUT_EN
          else if (wait_q == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_q  <= 1'b1;
            busy_q     <= 1'b0;
            core_rst_q <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            wait_q <= wait_q + TW'(1);
          end
`endif
        end
        S_SKIP: begin
          if (cnt_q == SKIP_LAST) begin
            cnt_q   <= '0;
            state_q <= S_CAPT;
          end else begin
            cnt_q <= cnt_nx;
          end
        end
        S_CAPT: begin
          result_q[cur_i*WORD +: WORD] <= core_out;
          if (cnt_q == A_LAST) begin
            inv_q      <= core_invalid;
            rv_q       <= 1'b1;
            core_rst_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= S_FIN;
          end else begin
            cnt_q <= cnt_nx;
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign result_inv   = inv_q;
  assign core_rst     = core_rst_q;
  assign core_in      = core_in_q;
`ifdef CSIDH_LINK_TIMEOUT_EN
  assign timeout      = timeout_q;
`else
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_csidh_host_link.sv
// Scoreboard bench for csidh_host_link: behavioural core model, cycle-level reference model and result monitor.
// Timeout scenario runs only when CSIDH_LINK_TIMEOUT_EN is defined.
module tb_csidh_host_link;

  localparam int N      = 512;
  localparam int KB     = 296;
  localparam int W      = 64;
  localparam int KC     = 6;
  localparam int OL     = 1;
  localparam int TO     = 64;
  localparam int CH     = N / W;
  localparam int NWORDS = CH + KC;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  a_in;
  logic [KB-1:0] key_in;
  logic          busy;
  logic [N-1:0]  result;
  logic          result_valid;
  logic          result_inv;
  logic          timeout;
  logic          core_rst;
  logic [W-1:0]  core_in;
  logic [W-1:0]  core_out;
  logic          core_done;
  logic          core_invalid;

  csidh_host_link #(
    .N(N), .KEY_BITS(KB), .WORD(W), .KEY_CHUNKS(KC), .OUT_LAT(OL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .key_in(key_in),
    .busy(busy), .result(result), .result_valid(result_valid), .result_inv(result_inv),
    .timeout(timeout), .core_rst(core_rst), .core_in(core_in), .core_out(core_out),
    .core_done(core_done), .core_invalid(core_invalid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Core model: absorbs NWORDS words, stays busy cfg_d cycles, then returns cfg_ret OL cycles after done.
  logic [N-1:0] cfg_ret   = '0;
  int           cfg_d     = 0;
  bit           cfg_inv   = 1'b0;
  bit           cfg_never = 1'b0;
  int           core_cyc  = 0;
  int           base;

  always @(posedge clk) core_cyc <= core_rst ? 0 : core_cyc + 1;
  assign base = NWORDS + cfg_d + OL;

  always_comb begin
    core_done    = 1'b0;
    core_out     = 64'hDEAD_BEEF_0BAD_F00D;
    core_invalid = ~cfg_inv;
    if (!core_rst && !cfg_never) begin
      if (core_cyc >= NWORDS + cfg_d) core_done = 1'b1;
      if (core_cyc >= base && core_cyc < base + CH) begin
        core_out = cfg_ret[(core_cyc - base)*W +: W];
        if (core_cyc == base + CH - 1) core_invalid = cfg_inv;
      end
    end
  end

  typedef struct {
    logic [N-1:0] res;
    bit           inv;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           cyc      = 0;
  int           acc      = -1000;
  int           fin      = -1000;
  int           kind     = 0;   // 0 none, 1 normal run, 2 run that times out
  logic [W-1:0] m_words[NWORDS];
  logic [N-1:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: tracks one run by its accept cycle and derives every per-cycle output from that.
  always @(negedge clk) begin : model
    bit              in_run;
    bit              crst_low;
    logic [W-1:0]    e_in;
    logic [KC*W-1:0] kp;
    in_run   = (kind != 0) && cyc > acc && cyc <= fin;
    crst_low = (kind != 0) && cyc >= acc + 2 && ((kind == 2) ? (cyc <= fin) : (cyc < fin));
    e_in     = '0;
    if (kind != 0 && cyc >= acc + 2 && cyc < acc + 2 + NWORDS) e_in = m_words[cyc - acc - 2];
    chk("busy", busy, in_run);
    chk("core_rst", core_rst, !crst_low);
    chk("core_in", core_in, e_in);
    chk("timeout", timeout, kind == 2 && cyc > fin);
    if (kind == 2 && cyc == fin + 1) chk("result_kept", result, last_res);
    if (rst) begin
      kind     = 0;
      last_res = '0;
      sb.delete();
    end else if (start && !in_run) begin
      acc = cyc;
      kp  = '0;
      kp[KB-1:0] = key_in;
      for (int k = 0; k < CH; k++) m_words[k] = a_in[k*W +: W];
      for (int k = 0; k < KC; k++) m_words[CH + k] = kp[k*W +: W];
      if (cfg_never) begin
        kind = 2;
        fin  = acc + 2 + NWORDS + TO - 1;
      end else begin
        kind = 1;
        fin  = acc + 1 + CH + KC + cfg_d + OL + CH + 1;
        sb.push_back('{res: cfg_ret, inv: cfg_inv, cyc: fin});
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (result_valid) begin
      if (sb.size() == 0) begin
        chk("rv_unexpected", result_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("rv_cycle", cyc, e.cyc);
        chk("result", result, e.res);
        chk("result_inv", result_inv, e.inv);
        last_res = e.res;
      end
    end else if (sb.size() != 0 && cyc >= sb[0].cyc) begin
      e = sb.pop_front();
      chk("rv_missing", result_valid, 1'b1);
    end
  end

  function automatic logic [N-1:0] rnd();
    logic [N-1:0] r;
    for (int i = 0; i < N/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic wait_rv(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (result_valid) break;
    end
    if (i == budget) chk("rv_timeout", result_valid, 1'b1);
  endtask

  task automatic issue(input logic [N-1:0] a, input logic [KB-1:0] k, input int d,
                       input logic [N-1:0] ret, input bit inv);
    a_in = a; key_in = k; cfg_d = d; cfg_ret = ret; cfg_inv = inv; cfg_never = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_one(input logic [N-1:0] a, input logic [KB-1:0] k, input int d,
                         input logic [N-1:0] ret, input bit inv);
    issue(a, k, d, ret, inv);
    wait_rv(60 + d);
    @(posedge clk); #1;
  endtask

  initial begin : stim
    logic [N-1:0]  a;
    logic [KB-1:0] ones;
    rst = 1'b1; start = 1'b0; a_in = '0; key_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_one('0, '0, 100, N'(1), 1'b0);

    for (int k = 0; k < CH; k++) a[k*W +: W] = 64'h1111_1111_1111_1111 * 64'(k);
    ones = '1;
    run_one(a, ones, int'($urandom_range(0, 20)), rnd(), 1'b0);

    run_one(rnd(), rnd()[KB-1:0], 7, rnd(), 1'b1);
    run_one(rnd(), rnd()[KB-1:0], 3, rnd(), 1'b0);
    run_one(rnd(), rnd()[KB-1:0], 0, rnd(), 1'b1);

    for (int r = 0; r < 5; r++)
      run_one(rnd(), rnd()[KB-1:0], int'($urandom_range(0, 40)), rnd(), 1'($urandom));

    // start held high across two complete runs
    a_in = rnd(); key_in = rnd()[KB-1:0]; cfg_d = 5; cfg_ret = rnd(); cfg_inv = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    wait_rv(100);
    @(posedge clk); #1;
    a_in = rnd(); key_in = rnd()[KB-1:0]; cfg_d = 9; cfg_ret = rnd(); cfg_inv = 1'b1;
    @(posedge clk); #1;
    wait_rv(100);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset during SEND_K word 3
    issue(rnd(), rnd()[KB-1:0], 30, rnd(), 1'b0);
    repeat (12) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;

    run_one(rnd(), rnd()[KB-1:0], int'($urandom_range(0, 20)), rnd(), 1'b0);

`ifdef CSIDH_LINK_TIMEOUT_EN
    a_in = rnd(); key_in = rnd()[KB-1:0]; cfg_never = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (NWORDS + TO + 20) @(posedge clk);
    #1;
    run_one(rnd(), rnd()[KB-1:0], 4, rnd(), 1'b0);
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", N'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
